// File: rtl/pix_src_sequencer_if.sv
// Pixel-source bus: camera and SPI inputs in, pixel stream and status out.
// The sequencer uses the slave side; the driver of the sources uses master.
interface pix_src_sequencer_if;
    logic        src_req;
    logic        cam_dv;
    logic        cam_frst;
    logic [15:0] cam_pix1;
    logic [15:0] cam_pix2;
    logic        spi_byte_vld;
    logic [7:0]  spi_byte;
    logic        spi_frst;
    logic        spi_abort;
    logic        out_en;
    logic        out_frst;
    logic [15:0] out_pix1;
    logic [15:0] out_pix2;
    logic [10:0] out_x;
    logic [10:0] out_y;
    logic        src_act;
    logic        frame_done;
    logic        drop_err;

    modport master (
        output src_req, cam_dv, cam_frst, cam_pix1, cam_pix2,
        output spi_byte_vld, spi_byte, spi_frst, spi_abort,
        input  out_en, out_frst, out_pix1, out_pix2,
        input  out_x, out_y, src_act, frame_done, drop_err
    );

    modport slave (
        input  src_req, cam_dv, cam_frst, cam_pix1, cam_pix2,
        input  spi_byte_vld, spi_byte, spi_frst, spi_abort,
        output out_en, out_frst, out_pix1, out_pix2,
        output out_x, out_y, src_act, frame_done, drop_err
    );
endinterface

// File: rtl/pix_src_sequencer.sv
// Selects camera or SPI pixel source for the SIFT front end, assembling SPI
// bytes into RGB565 pairs; source switches only at a frame boundary.
module pix_src_sequencer #(
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int PIX_BYTES = 6
) (
    input logic                clk,
    input logic                rst,
    pix_src_sequencer_if.slave bus
);
    typedef enum logic {S_CAM, S_SPI} state_t;

    localparam logic [10:0] X_LAST = 11'(FRAME_W - 1);
    localparam logic [10:0] Y_LAST = 11'(FRAME_H - 1);
    localparam logic [2:0]  B_LAST = 3'(PIX_BYTES - 1);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [4:0]  r_q, r_d;
    logic [5:0]  g_q, g_d;
    logic [15:0] acc2_q, acc2_d;
    logic        en_q, en_d;
    logic        frst_q, frst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] pix1_q, pix1_d;
    logic [15:0] pix2_q, pix2_d;
    logic [10:0] ox_q, ox_d;
    logic [10:0] oy_q, oy_d;

    logic        is_spi;
    logic        boundary;
    logic        frst_in;
    logic        vld_in;
    logic [15:0] in_pix1;
    logic [15:0] in_pix2;
    logic [10:0] px;
    logic [10:0] py;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CAM;
            x_q     <= '0;
            y_q     <= '0;
            bcnt_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            acc2_q  <= '0;
            en_q    <= 1'b0;
            frst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pix1_q  <= '0;
            pix2_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bcnt_q  <= bcnt_d;
            r_q     <= r_d;
            g_q     <= g_d;
            acc2_q  <= acc2_d;
            en_q    <= en_d;
            frst_q  <= frst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pix1_q  <= pix1_d;
            pix2_q  <= pix2_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        bcnt_d   = bcnt_q;
        r_d      = r_q;
        g_d      = g_q;
        acc2_d   = acc2_q;
        en_d     = 1'b0;
        frst_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        pix1_d   = pix1_q;
        pix2_d   = pix2_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        frst_in  = 1'b0;
        vld_in   = 1'b0;
        in_pix1  = bus.cam_pix1;
        in_pix2  = bus.cam_pix2;
        is_spi   = (state_q == S_SPI);
        boundary = (x_q == '0) && (y_q == '0) && (bcnt_q == '0);

        if ((!is_spi && bus.spi_byte_vld) || (is_spi && bus.cam_dv))
            err_d = 1'b1;

        // The switch cycle itself carries no frame reset or pixel.
        if (boundary && (bus.src_req != is_spi)) begin
            state_d = is_spi ? S_CAM : S_SPI;
        end else if (!is_spi) begin
            frst_in = bus.cam_frst;
            vld_in  = bus.cam_dv;
        end else begin
            frst_in = bus.spi_frst;
            in_pix1 = {r_q, g_q, bus.spi_byte[7:3]};
            in_pix2 = acc2_q;
            if (bus.spi_abort) begin
                bcnt_d = '0;
            end else if (bus.spi_byte_vld) begin
                bcnt_d = (bcnt_q == B_LAST) ? '0 : bcnt_q + 3'd1;
                unique case (bcnt_q)
                    3'd0, 3'd3: r_d = bus.spi_byte[7:3];
                    3'd1, 3'd4: g_d = bus.spi_byte[7:2];
                    3'd2:       acc2_d = {r_q, g_q, bus.spi_byte[7:3]};
                    default:    vld_in = 1'b1;
                endcase
            end
        end

        // Frame reset takes effect before a pixel in the same cycle.
        px = frst_in ? '0 : x_q;
        py = frst_in ? '0 : y_q;
        if (frst_in) begin
            frst_d = 1'b1;
            x_d    = '0;
            y_d    = '0;
        end
        if (vld_in) begin
            en_d   = 1'b1;
            pix1_d = in_pix1;
            pix2_d = in_pix2;
            ox_d   = px;
            oy_d   = py;
            if (px == X_LAST) begin
                x_d = '0;
                if (py == Y_LAST) begin
                    y_d    = '0;
                    done_d = 1'b1;
                end else begin
                    y_d = py + 11'd1;
                end
            end else begin
                x_d = px + 11'd1;
                y_d = py;
            end
        end
    end

    assign bus.out_en     = en_q;
    assign bus.out_frst   = frst_q;
    assign bus.out_pix1   = pix1_q;
    assign bus.out_pix2   = pix2_q;
    assign bus.out_x      = ox_q;
    assign bus.out_y      = oy_q;
    assign bus.src_act    = (state_q == S_SPI);
    assign bus.frame_done = done_q;
    assign bus.drop_err   = err_q;
endmodule

// File: tb/tb_pix_src_sequencer.sv
// Bench for pix_src_sequencer on a 4x2 frame, checked against a model that
// tracks a linear frame index and a queue of pending SPI bytes.
module tb_pix_src_sequencer;
    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pix_src_sequencer_if bus ();

    pix_src_sequencer #(
        .FRAME_W  (W),
        .FRAME_H  (H),
        .PIX_BYTES(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    bit          m_spi;
    bit          m_err;
    int          m_idx;
    logic [7:0]  m_bytes[$];
    bit          e_en, e_frst, e_done;
    logic [15:0] e_p1, e_p2;
    int          e_x, e_y;

    function automatic logic [15:0] pk(input logic [7:0] r, g, b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    function automatic void model_update();
        bit f, v;
        logic [15:0] p1, p2;
        e_en = 0;
        e_frst = 0;
        e_done = 0;
        if (rst) begin
            m_spi = 0; m_err = 0; m_idx = 0;
            m_bytes.delete();
            e_p1 = 0; e_p2 = 0; e_x = 0; e_y = 0;
            return;
        end
        if ((!m_spi && bus.spi_byte_vld) || (m_spi && bus.cam_dv))
            m_err = 1;
        if (m_idx == 0 && m_bytes.size() == 0 && bus.src_req != m_spi) begin
            m_spi = bus.src_req;
            return;
        end
        f = m_spi ? bus.spi_frst : bus.cam_frst;
        v = 0; p1 = 0; p2 = 0;
        if (!m_spi) begin
            v = bus.cam_dv; p1 = bus.cam_pix1; p2 = bus.cam_pix2;
        end else if (bus.spi_abort) begin
            m_bytes.delete();
        end else if (bus.spi_byte_vld) begin
            m_bytes.push_back(bus.spi_byte);
            if (m_bytes.size() == 6) begin
                v = 1;
                p2 = pk(m_bytes[0], m_bytes[1], m_bytes[2]);
                p1 = pk(m_bytes[3], m_bytes[4], m_bytes[5]);
                m_bytes.delete();
            end
        end
        if (f) begin
            m_idx = 0;
            e_frst = 1;
        end
        if (v) begin
            e_en = 1; e_p1 = p1; e_p2 = p2;
            e_x = m_idx % W;
            e_y = m_idx / W;
            e_done = (m_idx == W * H - 1);
            m_idx = (m_idx + 1) % (W * H);
        end
    endfunction

    function automatic logic [58:0] obs_vec();
        return {bus.out_en, bus.out_frst, bus.frame_done, bus.src_act,
                bus.drop_err, bus.out_x, bus.out_y, bus.out_pix1, bus.out_pix2};
    endfunction

    function automatic logic [58:0] exp_vec();
        return {e_en, e_frst, e_done, m_spi, m_err, 11'(e_x), 11'(e_y), e_p1, e_p2};
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cam_dv = 0; bus.cam_frst = 0;
        bus.cam_pix1 = 0; bus.cam_pix2 = 0;
        bus.spi_byte_vld = 0; bus.spi_byte = 0;
        bus.spi_frst = 0; bus.spi_abort = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        tick();
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
        end
        n_cmp++;
        if (obs_vec() !== 59'd0) begin
            n_bad++;
            $display("FAIL reset_zero: got %h want 0", obs_vec());
        end
        rst = 0;
    endtask

    task automatic test_cam_passthrough();
        bus.src_req = 0;
        for (int i = 0; i < 8; i++) begin
            bus.cam_dv = 1;
            bus.cam_pix1 = 16'h1234 + 16'(i);
            bus.cam_pix2 = 16'($urandom);
            tick();
            idle();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL cam_pair%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (bus.out_x !== 11'(i % W) || bus.out_y !== 11'(i / W) ||
                bus.out_pix1 !== 16'h1234 + 16'(i) || bus.out_en !== 1'b1 ||
                bus.frame_done !== (i == 7)) begin
                n_bad++;
                $display("FAIL cam_pos%0d: got x%0d y%0d p%h en%b fd%b want x%0d y%0d p%h en1 fd%0d",
                         i, bus.out_x, bus.out_y, bus.out_pix1, bus.out_en,
                         bus.frame_done, i % W, i / W, 16'h1234 + 16'(i), i == 7);
            end
            if ($urandom_range(1, 0) == 1) begin
                tick();
                n_cmp++;
                if (bus.out_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL cam_gap%0d: got en %b want 0", i, bus.out_en);
                end
            end
        end
        bus.cam_dv = 1;
        bus.cam_pix1 = 16'hBEEF;
        tick();
        idle();
        n_cmp++;
        if (bus.out_x !== 11'd0 || bus.out_y !== 11'd0 || bus.out_en !== 1'b1) begin
            n_bad++;
            $display("FAIL cam_wrap: got x%0d y%0d en%b want x0 y0 en1",
                     bus.out_x, bus.out_y, bus.out_en);
        end
    endtask

    task automatic test_spi_assembly();
        logic [7:0] seq[6];
        seq = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        bus.cam_frst = 1;
        tick();
        idle();
        bus.src_req = 1;
        tick();
        n_cmp++;
        if (bus.src_act !== 1'b1) begin
            n_bad++;
            $display("FAIL spi_switch: got src_act %b want 1", bus.src_act);
        end
        for (int i = 0; i < 6; i++) begin
            bus.spi_byte_vld = 1;
            bus.spi_byte = seq[i];
            tick();
            idle();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL spi_byte%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i < 5) begin
                for (int k = 0; k < int'($urandom_range(2, 0)); k++) tick();
            end
        end
        n_cmp++;
        if (bus.out_en !== 1'b1 || bus.out_pix2 !== 16'hF800 || bus.out_pix1 !== 16'h07E0) begin
            n_bad++;
            $display("FAIL spi_pack: got en%b p2 %h p1 %h want en1 p2 f800 p1 07e0",
                     bus.out_en, bus.out_pix2, bus.out_pix1);
        end
    endtask

    task automatic test_abort();
        logic [7:0] seq[6];
        int en_cnt;
        seq = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        en_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            bus.spi_byte_vld = 1;
            bus.spi_byte = 8'($urandom);
            tick();
            idle();
            en_cnt += int'(bus.out_en);
        end
        bus.spi_abort = 1;
        tick();
        idle();
        en_cnt += int'(bus.out_en);
        for (int i = 0; i < 6; i++) begin
            bus.spi_byte_vld = 1;
            bus.spi_byte = seq[i];
            tick();
            idle();
            en_cnt += int'(bus.out_en);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL abort_byte%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (en_cnt != 1 || bus.out_pix2 !== 16'h001F || bus.out_pix1 !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL abort_pair: got %0d en p2 %h p1 %h want 1 en p2 001f p1 ffff",
                     en_cnt, bus.out_pix2, bus.out_pix1);
        end
    endtask

    task automatic test_deferred_switch();
        bus.spi_frst = 1;
        tick();
        idle();
        bus.src_req = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.cam_dv = 1;
            bus.cam_pix1 = 16'($urandom);
            tick();
            idle();
        end
        bus.src_req = 1;
        for (int i = 0; i < 6; i++) begin
            bus.cam_dv = 1;
            bus.cam_pix1 = 16'($urandom);
            bus.cam_pix2 = 16'($urandom);
            tick();
            idle();
            n_cmp++;
            if (obs_vec() !== exp_vec() || bus.src_act !== 1'b0) begin
                n_bad++;
                $display("FAIL defer_pix%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL defer_done: got %b want 1", bus.frame_done);
        end
        tick();
        n_cmp++;
        if (bus.src_act !== 1'b1) begin
            n_bad++;
            $display("FAIL defer_act: got %b want 1", bus.src_act);
        end
        bus.cam_dv = 1;
        tick();
        idle();
        n_cmp++;
        if (bus.out_en !== 1'b0 || bus.drop_err !== 1'b1) begin
            n_bad++;
            $display("FAIL defer_drop: got en%b err%b want en0 err1", bus.out_en, bus.drop_err);
        end
    endtask

    task automatic test_frst_pixel();
        bus.src_req = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.cam_dv = 1;
            tick();
            idle();
        end
        bus.cam_dv = 1;
        bus.cam_frst = 1;
        bus.cam_pix1 = 16'hA5A5;
        tick();
        idle();
        n_cmp++;
        if (bus.out_frst !== 1'b1 || bus.out_en !== 1'b1 ||
            bus.out_x !== 11'd0 || bus.out_y !== 11'd0) begin
            n_bad++;
            $display("FAIL frst_pix: got f%b e%b x%0d y%0d want f1 e1 x0 y0",
                     bus.out_frst, bus.out_en, bus.out_x, bus.out_y);
        end
        bus.cam_dv = 1;
        tick();
        idle();
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.out_x !== 11'd1 || bus.out_y !== 11'd0) begin
            n_bad++;
            $display("FAIL frst_next: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        bus.cam_frst = 1;
        tick();
        idle();
        bus.src_req = 1;
        tick();
        bus.cam_dv = 1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.spi_byte_vld = 1;
            bus.spi_byte = 8'($urandom);
            tick();
            idle();
        end
        n_cmp++;
        if (bus.drop_err !== 1'b1 || bus.src_act !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got err%b act%b want err1 act1", bus.drop_err, bus.src_act);
        end
        rst = 1;
        bus.src_req = 0;
        tick();
        rst = 0;
        n_cmp++;
        if (obs_vec() !== 59'd0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid_zero: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(39, 0) == 0) bus.src_req = ~bus.src_req;
            rst              = ($urandom_range(199, 0) == 0);
            bus.cam_dv       = $urandom_range(1, 0) == 1;
            bus.cam_frst     = ($urandom_range(29, 0) == 0);
            bus.cam_pix1     = 16'($urandom);
            bus.cam_pix2     = 16'($urandom);
            bus.spi_byte_vld = $urandom_range(1, 0) == 1;
            bus.spi_byte     = 8'($urandom);
            bus.spi_frst     = ($urandom_range(39, 0) == 0);
            bus.spi_abort    = ($urandom_range(49, 0) == 0);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        bus.src_req = 0;
        idle();
        test_reset();
        test_cam_passthrough();
        test_spi_assembly();
        test_abort();
        test_deferred_switch();
        test_frst_pixel();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pix_src_sequencer.md
# pix_src_sequencer

Controller that owns the pixel-stream input of the SIFT front end (PixCoordinator, octaveModule, DoG taps). It selects between the live camera stream and SPI-injected test frames, and assembles SPI bytes into RGB565 pixel pairs. Source switches happen only on frame boundaries. It produces the single enable/frame-reset/pixel stream that drives the octave pipeline, plus its own x/y position, frame-done and error status.

## Interface
- FRAME_W, 640, pixels per line
- FRAME_H, 480, lines per frame
- PIX_BYTES, 6, SPI bytes per pixel pair (fixed at 6; other values unsupported)

- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_req  in  1  requested source: 0 = camera, 1 = SPI
- cam_dv  in  1  camera pixel-pair valid
- cam_frst  in  1  camera frame reset pulse
- cam_pix1, cam_pix2  in  16 each  camera RGB565 pixels
- spi_byte_vld  in  1  one-cycle strobe, new SPI data byte
- spi_byte  in  8  SPI data byte
- spi_frst  in  1  SPI-side frame reset pulse (screen reset command)
- spi_abort  in  1  chip-select released; flush any partial pixel
- out_en  out  1  pixel-pair valid to downstream
- out_frst  out  1  frame reset to downstream (one cycle)
- out_pix1, out_pix2  out  16 each  RGB565 pixel pair
- out_x  out  11  column of pair on out_pix (valid with out_en)
- out_y  out  11  row of pair on out_pix
- src_act  out  1  active source: 0 = camera, 1 = SPI
- frame_done  out  1  one-cycle pulse with the last pixel of a frame
- drop_err  out  1  sticky: input from the inactive source was discarded

## Operation
- States: S_CAM (reset state), S_SPI. src_act = (state == S_SPI).
- Boundary condition: position counter is (0,0) and byte counter is 0. A switch happens only in a cycle where the boundary condition holds and src_req differs from src_act; it takes effect next cycle. No pixel is emitted in the switch cycle.
- S_CAM: cam_dv emits out_pix1/2 = cam_pix1/2. cam_frst drives out_frst and clears position. SPI bytes and spi_frst are ignored; any spi_byte_vld sets drop_err.
- S_SPI:
  - Byte counter 0..5 advances on spi_byte_vld.
  - Bytes 0,1,2 = R,G,B of pix2; bytes 3,4,5 = R,G,B of pix1.
  - Packing: {R[7:3],G[7:2],B[7:3]}.
  - The 6th byte emits the pair and the counter wraps to 0.
  - spi_frst drives out_frst and clears position.
  - spi_abort clears the byte counter and discards the partial pixel; a byte arriving in the same cycle is dropped.
  - Camera inputs are ignored; cam_dv sets drop_err.
- Position: out_x increments per emitted pair. At FRAME_W-1 it wraps to 0 and out_y increments. The pair at (FRAME_W-1, FRAME_H-1) asserts frame_done, then the position wraps to (0,0).
- Frame reset and pixel in the same cycle: the reset applies first. The pixel is emitted at (0,0), out_frst and out_en are asserted together, and the next position is (1,0).
- drop_err clears only on rst.

## Timing
- All outputs are registered. Reset values:
  - out_en, out_frst, frame_done, drop_err, src_act: 0
  - out_pix1/2: 0
  - out_x/out_y: 0
  - byte counter: 0
  - state: S_CAM
- Camera path latency: cam_dv at cycle N gives out_en at N+1.
- SPI path latency: 6th spi_byte_vld at N gives out_en at N+1.
- out_frst is asserted at N+1 for a frame-reset input at N.
- out_en, out_frst and frame_done are single-cycle pulses. There is no backpressure; downstream must accept every out_en.
- Switch latency: src_req change at a boundary gives src_act change 1 cycle later. If not at a boundary, the switch waits for the next frame_done or the next frame reset of the active source.
- rst mid-frame or mid-pixel: everything returns to reset values next cycle, and any partial SPI pixel is lost.

## Test plan
- Camera pass-through, FRAME_W=4, FRAME_H=2:
  - Stimulus: 8 cam_dv pulses with cam_pix1=16'h1234+i.
  - Required: out_en 1 cycle later each time with matching data; out_x/out_y sequence (0,0),(1,0)…(3,1); frame_done with the 8th pair; position returns to (0,0).
- SPI assembly:
  - Stimulus: in S_SPI, bytes FF,00,00,00,FF,00.
  - Required: out_pix2=16'hF800 and out_pix1=16'h07E0, one cycle after the 6th byte.
- Abort mid-pixel:
  - Stimulus: 3 bytes, then spi_abort, then 6 bytes 00,00,FF,FF,FF,FF.
  - Required: exactly one out_en with pix2=16'h001F and pix1=16'hFFFF.
- Deferred switch:
  - Stimulus: src_req=1 raised at position (2,0).
  - Required: src_act stays 0 until the cycle after the pixel that asserts frame_done, then becomes 1. cam_dv after the switch gives no out_en and sets drop_err=1.
- Simultaneous frame reset and pixel:
  - Stimulus: cam_frst and cam_dv together at position (3,0).
  - Required: out_frst=1 and out_en=1 at (0,0); the next pair lands at (1,0).
- Reset mid-operation:
  - Stimulus: rst during S_SPI with byte count 4 and drop_err=1.
  - Required: all outputs 0 and state S_CAM the following cycle.
